// File: rtl/iterative_comparator_unit_pkg.sv
// Shared comparator header: operation encodings, FSM state codes and
// small helpers used by the iterative comparator and anything that decodes ops.
package iterative_comparator_unit_pkg;

  localparam int CMP_OP_WIDTH = 4;

  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_EQ   = 4'd0;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_NE   = 4'd1;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_LT   = 4'd2;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_GE   = 4'd3;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_LTU  = 4'd4;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_GEU  = 4'd5;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_MIN  = 4'd6;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_MAX  = 4'd7;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_MINU = 4'd8;
  localparam logic [CMP_OP_WIDTH-1:0] CMP_SEL_MAXU = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ordering decision taken at the first chunk where the operands differ
  typedef struct packed {
    logic lt;
    logic gt;
  } cmp_decision_t;

  function automatic logic is_signed_op(input logic [CMP_OP_WIDTH-1:0] op);
    return (op == CMP_SEL_LT) || (op == CMP_SEL_GE) ||
           (op == CMP_SEL_MIN) || (op == CMP_SEL_MAX);
  endfunction

  function automatic logic is_known_op(input logic [CMP_OP_WIDTH-1:0] op);
    return op <= CMP_SEL_MAXU;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one operand chunk. Flipping the top bit
// of both inputs turns the unsigned compare into a two's-complement one for
// the chunk that holds the operand sign bit.
module comparator_chunk #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_msb,
  output logic             lt,
  output logic             gt
);

  logic [WIDTH-1:0] msb_mask;
  logic [WIDTH-1:0] a_adj;
  logic [WIDTH-1:0] b_adj;

  assign msb_mask = WIDTH'(invert_msb) << (WIDTH - 1);
  assign a_adj    = a ^ msb_mask;
  assign b_adj    = b ^ msb_mask;
  assign lt       = a_adj < b_adj;
  assign gt       = a_adj > b_adj;

endmodule

// File: rtl/iterative_comparator_unit.sv
// Multi-cycle comparator: walks the operands one chunk per cycle from the MSB
// end, optionally stopping at the first differing chunk, and presents a
// registered boolean result plus the selected operand for MIN/MAX ops.
module iterative_comparator_unit
  import iterative_comparator_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int EARLY_EXIT  = 1
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic [XLEN-1:0]         i_Input_A,
  input  logic [XLEN-1:0]         i_Input_B,
  input  logic [CMP_OP_WIDTH-1:0] i_Compare_Select,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  input  logic                    i_Flush,
  output logic                    o_Result_Valid,
  input  logic                    i_Result_Ready,
  output logic                    o_Compare_Result,
  output logic [XLEN-1:0]         o_Result_Value
);

  localparam int NUM_CHUNKS = XLEN / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if ((CHUNK_WIDTH < 1) || (CHUNK_WIDTH > XLEN) || ((XLEN % CHUNK_WIDTH) != 0)) begin : g_bad_width
    $error("iterative_comparator_unit: XLEN must be a nonzero multiple of CHUNK_WIDTH");
  end

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic [XLEN-1:0]         op_a;
  logic [XLEN-1:0]         op_b;
  logic [CMP_OP_WIDTH-1:0] op_sel;
  cmp_decision_t           decision;
  logic                    decision_valid;
  logic                    result_valid;
  logic                    compare_result;
  logic [XLEN-1:0]         result_value;

  logic [CHUNK_WIDTH-1:0]  chunk_a;
  logic [CHUNK_WIDTH-1:0]  chunk_b;
  logic                    invert_msb;
  logic                    chunk_lt;
  logic                    chunk_gt;
  logic                    chunk_differs;
  logic                    final_lt;
  logic                    final_gt;
  logic                    finish;
  logic                    next_result;
  logic [XLEN-1:0]         next_value;

  // Select the operand chunk addressed by the current index
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx == IDX_W'(i)) begin
        chunk_a = op_a[i*CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_b = op_b[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

  assign invert_msb = is_signed_op(op_sel) && (idx == LAST_IDX);

  comparator_chunk #(
    .WIDTH(CHUNK_WIDTH)
  ) u_chunk (
    .a         (chunk_a),
    .b         (chunk_b),
    .invert_msb(invert_msb),
    .lt        (chunk_lt),
    .gt        (chunk_gt)
  );

  assign chunk_differs = chunk_lt | chunk_gt;
  assign final_lt      = decision_valid ? decision.lt : chunk_lt;
  assign final_gt      = decision_valid ? decision.gt : chunk_gt;
  assign finish        = !is_known_op(op_sel) || (idx == '0) ||
                         ((EARLY_EXIT != 0) && chunk_differs);

  // Turn the overall ordering into the op's boolean and selected operand; ties pick A
  always_comb begin
    next_result = 1'b0;
    next_value  = '0;
    case (op_sel)
      CMP_SEL_EQ:  next_result = !final_lt && !final_gt;
      CMP_SEL_NE:  next_result = final_lt || final_gt;
      CMP_SEL_LT,
      CMP_SEL_LTU: next_result = final_lt;
      CMP_SEL_GE,
      CMP_SEL_GEU: next_result = !final_lt;
      CMP_SEL_MIN,
      CMP_SEL_MINU: begin
        next_result = !final_gt;
        next_value  = next_result ? op_a : op_b;
      end
      CMP_SEL_MAX,
      CMP_SEL_MAXU: begin
        next_result = !final_lt;
        next_value  = next_result ? op_a : op_b;
      end
      default: begin
        next_result = 1'b0;
        next_value  = '0;
      end
    endcase
  end

  // Request FSM: accept, iterate over chunks, hold the result until consumed
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      op_a           <= '0;
      op_b           <= '0;
      op_sel         <= '0;
      decision       <= '0;
      decision_valid <= 1'b0;
      result_valid   <= 1'b0;
      compare_result <= 1'b0;
      result_value   <= '0;
    end else if (i_Flush) begin
      state          <= ST_IDLE;
      result_valid   <= 1'b0;
      compare_result <= 1'b0;
      result_value   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_Valid) begin
            op_a           <= i_Input_A;
            op_b           <= i_Input_B;
            op_sel         <= i_Compare_Select;
            idx            <= LAST_IDX;
            decision       <= '0;
            decision_valid <= 1'b0;
            state          <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!decision_valid && chunk_differs) begin
            decision       <= '{lt: chunk_lt, gt: chunk_gt};
            decision_valid <= 1'b1;
          end
          if (finish) begin
            state          <= ST_DONE;
            result_valid   <= 1'b1;
            compare_result <= next_result;
            result_value   <= next_value;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DONE: begin
          if (i_Result_Ready) begin
            state          <= ST_IDLE;
            result_valid   <= 1'b0;
            compare_result <= 1'b0;
            result_value   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_Ready          = (state == ST_IDLE);
  assign o_Result_Valid   = result_valid;
  assign o_Compare_Result = compare_result;
  assign o_Result_Value   = result_value;

endmodule

// File: tb/tb_iterative_comparator_unit.sv
// Bench for iterative_comparator_unit: one early-exit and one constant-time
// instance share the same stimulus; a latency/result model checks both every
// cycle and directed vectors pin literal results and latencies.
module tb_iterative_comparator_unit;
  import iterative_comparator_unit_pkg::*;

  localparam int XLEN = 32;
  localparam int CW   = 8;
  localparam int NCH  = XLEN / CW;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid;
  logic                    flush;
  logic                    res_ready;
  logic [XLEN-1:0]         a;
  logic [XLEN-1:0]         b;
  logic [CMP_OP_WIDTH-1:0] sel;

  logic            ready0, rvalid0, cres0;
  logic [XLEN-1:0] rval0;
  logic            ready1, rvalid1, cres1;
  logic [XLEN-1:0] rval1;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  int              m_phase    [2];
  int              m_cnt      [2];
  logic            m_res      [2];
  logic [XLEN-1:0] m_val      [2];
  logic            m_pend_res [2];
  logic [XLEN-1:0] m_pend_val [2];

  iterative_comparator_unit #(.XLEN(XLEN), .CHUNK_WIDTH(CW), .EARLY_EXIT(1)) dut_early (
    .i_Clock(clk), .i_Reset(rst), .i_Input_A(a), .i_Input_B(b),
    .i_Compare_Select(sel), .i_Valid(valid), .o_Ready(ready0), .i_Flush(flush),
    .o_Result_Valid(rvalid0), .i_Result_Ready(res_ready),
    .o_Compare_Result(cres0), .o_Result_Value(rval0)
  );

  iterative_comparator_unit #(.XLEN(XLEN), .CHUNK_WIDTH(CW), .EARLY_EXIT(0)) dut_const (
    .i_Clock(clk), .i_Reset(rst), .i_Input_A(a), .i_Input_B(b),
    .i_Compare_Select(sel), .i_Valid(valid), .o_Ready(ready1), .i_Flush(flush),
    .o_Result_Valid(rvalid1), .i_Result_Ready(res_ready),
    .o_Compare_Result(cres1), .o_Result_Value(rval1)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference result from plain arithmetic, latency from the first differing byte
  function automatic void modelCalc(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                    input logic [CMP_OP_WIDTH-1:0] op, input int early,
                                    output logic r, output logic [XLEN-1:0] v, output int lat);
    logic slt, sgt, ult, ugt, known;
    slt   = $signed(x) < $signed(y);
    sgt   = $signed(x) > $signed(y);
    ult   = x < y;
    ugt   = x > y;
    r     = 1'b0;
    v     = '0;
    lat   = NCH;
    known = 1'b1;
    case (op)
      CMP_SEL_EQ:   r = (x == y);
      CMP_SEL_NE:   r = (x != y);
      CMP_SEL_LT:   r = slt;
      CMP_SEL_GE:   r = !slt;
      CMP_SEL_LTU:  r = ult;
      CMP_SEL_GEU:  r = !ult;
      CMP_SEL_MIN:  begin r = !sgt; v = r ? x : y; end
      CMP_SEL_MAX:  begin r = !slt; v = r ? x : y; end
      CMP_SEL_MINU: begin r = !ugt; v = r ? x : y; end
      CMP_SEL_MAXU: begin r = !ult; v = r ? x : y; end
      default:      begin known = 1'b0; lat = 1; end
    endcase
    if (known && early != 0) begin
      for (int k = NCH; k >= 1; k--) begin
        if (x[(NCH-k)*CW +: CW] != y[(NCH-k)*CW +: CW]) lat = k;
      end
    end
  endfunction

  // Cycle model: phase 0 idle, 1 computing, 2 result held
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_phase[i] = 0; m_res[i] = 1'b0; m_val[i] = '0;
      end else if (flush) begin
        m_phase[i] = 0; m_res[i] = 1'b0; m_val[i] = '0;
      end else begin
        case (m_phase[i])
          0: if (valid) begin
               modelCalc(a, b, sel, (i == 0) ? 1 : 0, m_pend_res[i], m_pend_val[i], m_cnt[i]);
               m_phase[i] = 1;
             end
          1: begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin
                 m_phase[i] = 2; m_res[i] = m_pend_res[i]; m_val[i] = m_pend_val[i];
               end
             end
          default: if (res_ready) begin
               m_phase[i] = 0; m_res[i] = 1'b0; m_val[i] = '0;
             end
        endcase
      end
    end
  end

  task automatic checkInstance(input int inst, input logic rd, input logic rv,
                               input logic cr, input logic [XLEN-1:0] vl);
    logic want_rd, want_rv;
    want_rd = (m_phase[inst] == 0);
    want_rv = (m_phase[inst] == 2);
    n_checks++;
    if (rd !== want_rd || rv !== want_rv || cr !== m_res[inst] || vl !== m_val[inst]) begin
      n_fail++;
      $display("[TB] FAIL model_cmp inst%0d t=%0t: got rdy=%b vld=%b res=%b val=%h, want rdy=%b vld=%b res=%b val=%h",
               inst, $time, rd, rv, cr, vl, want_rd, want_rv, m_res[inst], m_val[inst]);
    end
  endtask

  // Compare both instances against the model away from the clock edge
  always @(negedge clk) begin
    if (check_en) begin
      checkInstance(0, ready0, rvalid0, cres0, rval0);
      checkInstance(1, ready1, rvalid1, cres1, rval1);
    end
  end

  task automatic checkVal(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [CMP_OP_WIDTH-1:0] op, input logic [XLEN-1:0] x,
                               input logic [XLEN-1:0] y);
    @(negedge clk);
    a = x; b = y; sel = op; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic exp_res, input logic [XLEN-1:0] exp_val,
                             input int lat0, input int lat1, input bit release_it);
    int seen0, seen1;
    seen0 = 0; seen1 = 0;
    for (int c = 1; c <= 40 && (seen0 == 0 || seen1 == 0); c++) begin
      @(posedge clk); #1;
      if (seen0 == 0 && rvalid0) seen0 = c;
      if (seen1 == 0 && rvalid1) seen1 = c;
    end
    checkVal({name, "_lat_early"}, 32'(seen0), 32'(lat0));
    checkVal({name, "_lat_const"}, 32'(seen1), 32'(lat1));
    checkVal({name, "_res_early"}, {31'd0, cres0}, {31'd0, exp_res});
    checkVal({name, "_val_early"}, rval0, exp_val);
    checkVal({name, "_res_const"}, {31'd0, cres1}, {31'd0, exp_res});
    checkVal({name, "_val_const"}, rval1, exp_val);
    if (release_it) begin
      @(negedge clk); res_ready = 1'b1;
      @(negedge clk); res_ready = 1'b0;
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    rst = 1'b0; valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; sel = '0;
    #2 rst = 1'b1;
    #20 rst = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    checkVal("reset_ready",  {30'd0, ready0, ready1},   32'h3);
    checkVal("reset_valid",  {30'd0, rvalid0, rvalid1}, 32'h0);
    checkVal("reset_result", {30'd0, cres0, cres1},     32'h0);
    checkVal("reset_value",  rval0 | rval1,             32'h0);

    applyStimulus(CMP_SEL_LT,   32'hFFFFFFFF, 32'h1);        checkOutput("lt_neg",   1'b1, 32'h0, 1, 4, 1'b1);
    applyStimulus(CMP_SEL_LTU,  32'hFFFFFFFF, 32'h1);        checkOutput("ltu_big",  1'b0, 32'h0, 1, 4, 1'b1);
    applyStimulus(CMP_SEL_EQ,   32'h12345678, 32'h12345678); checkOutput("eq_same",  1'b1, 32'h0, 4, 4, 1'b1);
    applyStimulus(CMP_SEL_NE,   32'h12345678, 32'h12345678); checkOutput("ne_same",  1'b0, 32'h0, 4, 4, 1'b1);
    applyStimulus(CMP_SEL_GE,   32'h80000000, 32'h7FFFFFFF); checkOutput("ge_min",   1'b0, 32'h0, 1, 4, 1'b1);
    applyStimulus(CMP_SEL_GE,   32'h01000000, 32'h00FFFFFF); checkOutput("ge_nflip", 1'b1, 32'h0, 1, 4, 1'b1);
    applyStimulus(CMP_SEL_MAX,  32'hFFFFFFF0, 32'h5);        checkOutput("max_s",    1'b0, 32'h5, 1, 4, 1'b1);
    applyStimulus(CMP_SEL_MAXU, 32'hFFFFFFF0, 32'h5);        checkOutput("maxu",     1'b1, 32'hFFFFFFF0, 1, 4, 1'b1);
    applyStimulus(CMP_SEL_MIN,  32'h7, 32'h7);               checkOutput("min_tie",  1'b1, 32'h7, 4, 4, 1'b1);
    applyStimulus(4'hF,         32'h1, 32'h2);               checkOutput("unknown",  1'b0, 32'h0, 1, 1, 1'b1);
    applyStimulus(CMP_SEL_LTU,  32'h12345600, 32'h12345700); checkOutput("ltu_b1",   1'b1, 32'h0, 3, 4, 1'b1);
    applyStimulus(CMP_SEL_MINU, 32'h00000100, 32'h000000FF); checkOutput("minu_b1",  1'b0, 32'hFF, 3, 4, 1'b1);

    // Back-pressure: result held, new request ignored until released
    applyStimulus(CMP_SEL_LT, 32'hFFFFFFFF, 32'h1);
    checkOutput("hold", 1'b1, 32'h0, 1, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 32'h5; b = 32'h5; sel = CMP_SEL_EQ; valid = 1'b1;
      checkVal("hold_ready", {30'd0, ready0, ready1}, 32'h0);
      checkVal("hold_res",   {30'd0, cres0, cres1},   32'h3);
    end
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    checkVal("release_ready", {30'd0, ready0, ready1}, 32'h3);
    @(posedge clk); #1;
    checkVal("next_accept", {30'd0, ready0, ready1}, 32'h0);
    @(negedge clk); valid = 1'b0;
    checkOutput("after_hold", 1'b1, 32'h0, 4, 4, 1'b1);

    // Flush while computing
    applyStimulus(CMP_SEL_EQ, 32'hAA, 32'hAA);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("flush_idle", {28'd0, ready0, ready1, rvalid0, rvalid1}, 32'hC);
    end

    // Valid together with flush is not accepted
    @(negedge clk); a = 32'h3; b = 32'h4; sel = CMP_SEL_LT; valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    checkVal("valid_flush", {30'd0, ready0, ready1}, 32'h3);
    @(negedge clk); valid = 1'b0; flush = 1'b0;

    // Asynchronous reset in the middle of a computation
    applyStimulus(CMP_SEL_EQ, 32'h55, 32'h55);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checkVal("async_rst", {28'd0, ready0, ready1, rvalid0, rvalid1}, 32'hC);
    checkVal("async_rst_out", rval0 | rval1 | {30'd0, cres0, cres1}, 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkVal("post_rst_idle", {30'd0, rvalid0, rvalid1}, 32'h0);
    end

    applyStimulus(CMP_SEL_GEU, 32'h00000001, 32'h80000000);  checkOutput("geu_recover", 1'b0, 32'h0, 1, 4, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
